// File: rtl/stdp_sched_q14.sv
// rtl/stdp_sched_q14.sv - per-timestep STDP weight read-modify-write scheduler
// Optional STDP_SCHED_STATS_EN adds saturating ltp_count/ltd_count outputs.
module stdp_sched_q14 #(
    parameter int F  = 48,
    parameter int N  = 96,
    parameter int AW = $clog2(F*N)
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 enable,
    input  logic                 step_valid,
    output logic                 step_ready,
    input  logic [F-1:0]         pre_bits,
    input  logic [N-1:0]         post_bits,
    input  logic signed [15:0]   eta,
    input  logic [7:0]           eta_shift,
    input  logic signed [15:0]   wmin,
    input  logic signed [15:0]   wmax,
    output logic                 rd_req,
    output logic [AW-1:0]        rd_addr,
    input  logic                 rd_gnt,
    input  logic signed [15:0]   rd_data,
    output logic                 w_we,
    output logic [AW-1:0]        w_addr,
    output logic signed [15:0]   w_wdata,
    output logic                 busy,
    output logic                 done
`ifdef STDP_SCHED_STATS_EN
    ,
    output logic [31:0]          ltp_count,
    output logic [31:0]          ltd_count
`endif
);

    localparam int FW = (F > 1) ? $clog2(F) : 1;
    localparam int NW = $clog2(N + 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_SCAN = 3'd1;
    localparam logic [2:0] S_RD   = 3'd2;
    localparam logic [2:0] S_WAIT = 3'd3;
    localparam logic [2:0] S_WR   = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;

    logic [2:0]         state_q, state_d;
    logic [F-1:0]       pre_q, pre_d;
    logic [N-1:0]       post_q, post_d;
    logic [FW-1:0]      f_q, f_d;
    logic [NW-1:0]      n_q, n_d;
    logic signed [15:0] dltp_q, dltp_d;
    logic signed [15:0] dltd_q, dltd_d;
    logic signed [15:0] wdata_q, wdata_d;

    logic [AW-1:0]      addr;
    logic [N-1:0]       n_onehot;
    logic [F-1:0]       f_onehot;
    logic               post_hit;
    logic               pre_hit;
    logic signed [15:0] eta_sh;
    logic signed [16:0] sum;
    logic signed [16:0] wmin_x;
    logic signed [16:0] wmax_x;
    logic signed [15:0] new_w;

    assign addr     = AW'(32'(f_q) * 32'(N) + 32'(n_q));
    assign n_onehot = {{(N-1){1'b0}}, 1'b1} << n_q;
    assign f_onehot = {{(F-1){1'b0}}, 1'b1} << f_q;
    assign post_hit = |(post_q & n_onehot);
    assign pre_hit  = |(pre_q & f_onehot);
    assign eta_sh   = eta >>> eta_shift;

    // Upper clamp is checked first so that an inverted window (wmin > wmax) always yields wmax.
    always_comb begin
        wmin_x = {wmin[15], wmin};
        wmax_x = {wmax[15], wmax};
        sum    = {rd_data[15], rd_data} +
                 (pre_hit ? {dltp_q[15], dltp_q} : -{dltd_q[15], dltd_q});
        if (sum > wmax_x || wmin_x > wmax_x) begin
            new_w = wmax;
        end else if (sum < wmin_x) begin
            new_w = wmin;
        end else begin
            new_w = sum[15:0];
        end
    end

    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        post_d  = post_q;
        f_d     = f_q;
        n_d     = n_q;
        dltp_d  = dltp_q;
        dltd_d  = dltd_q;
        wdata_d = wdata_q;
        case (state_q)
            S_IDLE: begin
                if (step_valid) begin
                    pre_d   = pre_bits;
                    post_d  = post_bits;
                    f_d     = '0;
                    n_d     = '0;
                    dltp_d  = eta_sh;
                    dltd_d  = eta_sh >>> 1;
                    state_d = (enable && (|post_bits)) ? S_SCAN : S_DONE;
                end
            end
            S_SCAN: begin
                // Processed columns are cleared, so any remaining bit lies at or above n.
                if (post_q == '0) begin
                    state_d = S_DONE;
                end else if (post_hit) begin
                    f_d     = '0;
                    state_d = S_RD;
                end else begin
                    n_d = n_q + NW'(1);
                end
            end
            S_RD: begin
                if (rd_gnt) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                wdata_d = new_w;
                state_d = S_WR;
            end
            S_WR: begin
                if (f_q == FW'(F - 1)) begin
                    post_d  = post_q & ~n_onehot;
                    n_d     = n_q + NW'(1);
                    f_d     = '0;
                    state_d = S_SCAN;
                end else begin
                    f_d     = f_q + FW'(1);
                    state_d = S_RD;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            pre_q   <= '0;
            post_q  <= '0;
            f_q     <= '0;
            n_q     <= '0;
            dltp_q  <= '0;
            dltd_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            post_q  <= post_d;
            f_q     <= f_d;
            n_q     <= n_d;
            dltp_q  <= dltp_d;
            dltd_q  <= dltd_d;
            wdata_q <= wdata_d;
        end
    end

    assign step_ready = (state_q == S_IDLE);
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign rd_req     = (state_q == S_RD);
    assign w_we       = (state_q == S_WR);
    assign rd_addr    = addr;
    assign w_addr     = addr;
    assign w_wdata    = wdata_q;

`ifdef STDP_SCHED_STATS_EN
    logic [31:0] ltp_q, ltp_d;
    logic [31:0] ltd_q, ltd_d;

    always_comb begin
        ltp_d = ltp_q;
        ltd_d = ltd_q;
        if (state_q == S_WR) begin
            if (pre_hit) begin
                if (ltp_q != '1) ltp_d = ltp_q + 32'd1;
            end else begin
                if (ltd_q != '1) ltd_d = ltd_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ltp_q <= '0;
            ltd_q <= '0;
        end else begin
            ltp_q <= ltp_d;
            ltd_q <= ltd_d;
        end
    end

    assign ltp_count = ltp_q;
    assign ltd_count = ltd_q;
`endif

endmodule

// File: tb/tb_stdp_sched_q14.sv
// tb/tb_stdp_sched_q14.sv - scoreboard bench for stdp_sched_q14 with F=4, N=3
module tb_stdp_sched_q14;
    localparam int F  = 4;
    localparam int N  = 3;
    localparam int AW = 4;

    logic               clk = 1'b0;
    logic               rstn = 1'b0;
    logic               enable = 1'b0;
    logic               step_valid = 1'b0;
    logic               step_ready;
    logic [F-1:0]       pre_bits = '0;
    logic [N-1:0]       post_bits = '0;
    logic signed [15:0] eta = '0;
    logic [7:0]         eta_shift = '0;
    logic signed [15:0] wmin = -16'sd16384;
    logic signed [15:0] wmax = 16'sd16384;
    logic               rd_req;
    logic [AW-1:0]      rd_addr;
    logic               rd_gnt = 1'b1;
    logic signed [15:0] rd_data = '0;
    logic               w_we;
    logic [AW-1:0]      w_addr;
    logic signed [15:0] w_wdata;
    logic               busy;
    logic               done;

    stdp_sched_q14 #(.F(F), .N(N), .AW(AW)) dut (
        .clk(clk), .rstn(rstn), .enable(enable), .step_valid(step_valid),
        .step_ready(step_ready), .pre_bits(pre_bits), .post_bits(post_bits),
        .eta(eta), .eta_shift(eta_shift), .wmin(wmin), .wmax(wmax),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_data(rd_data),
        .w_we(w_we), .w_addr(w_addr), .w_wdata(w_wdata), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int addr;
        int data;
    } wr_t;

    wr_t                exp_q[$];
    wr_t                e;
    logic signed [15:0] mem [0:15];
    int  n_checks = 0;
    int  n_fail = 0;
    int  cyc = 0;
    int  first_rd = -1;
    int  last_we = -1;
    int  done_cyc = -1;
    int  rd_cnt = 0;
    int  we_cnt = 0;
    bit  pend = 1'b0;
    int  pa = 0;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic push_exp(input int a, input int d);
        wr_t w;
        w.addr = a;
        w.data = d;
        exp_q.push_back(w);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 16; i++) mem[i] = '0;
    endtask

    // Monitor: records step activity and pops the scoreboard on every write.
    always @(negedge clk) begin
        cyc++;
        pend = rd_req && rd_gnt;
        pa   = int'(rd_addr);
        if (rd_req) begin
            rd_cnt++;
            if (first_rd < 0) first_rd = cyc;
        end
        if (done) done_cyc = cyc;
        if (w_we) begin
            last_we = cyc;
            we_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_write_addr", int'(w_addr), -1);
            end else begin
                e = exp_q.pop_front();
                check("write_addr", int'(w_addr), e.addr);
                check("write_data", int'(w_wdata), e.data);
            end
            mem[w_addr] = w_wdata;
        end
    end

    always @(posedge clk) begin
        #1;
        if (pend) rd_data = mem[pa];
    end

    task automatic clear_stats();
        first_rd = -1;
        last_we  = -1;
        done_cyc = -1;
        rd_cnt   = 0;
        we_cnt   = 0;
    endtask

    task automatic start_step(input logic en, input logic [F-1:0] pre, input logic [N-1:0] post,
                              input logic signed [15:0] et, input logic [7:0] sh, output int acc);
        int k;
        k = 0;
        while (!step_ready && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        check("step_ready_before_step", int'(step_ready), 1);
        clear_stats();
        enable = en; pre_bits = pre; post_bits = post; eta = et; eta_shift = sh;
        step_valid = 1'b1;
        @(negedge clk); #1;
        acc = cyc;
        @(posedge clk); #1;
        step_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int k;
        k = 0;
        while (done_cyc < 0 && k < 300) begin
            @(posedge clk); #1;
            k++;
        end
        if (done_cyc < 0) check({name, "_done_timeout"}, 0, 1);
        @(posedge clk); #1;
        check({name, "_pending_writes"}, exp_q.size(), 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int acc;
        int bad;
        int k;
        clear_mem();

        // Reset values and idle behaviour.
        repeat (3) @(negedge clk);
        check("rst_step_ready", int'(step_ready), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_rd_req_w_we_done", int'({rd_req, w_we, done}), 0);
        check("rst_addrs_data", int'({rd_addr, w_addr, w_wdata}), 0);
        @(posedge clk); #1;
        rstn = 1'b1;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (!step_ready || busy || rd_req || w_we) bad++;
        end
        check("idle_20_cycles_bad", bad, 0);

        // Single column n=1: dltp=1024, dltd=512.
        @(posedge clk); #1;
        push_exp(1, 1024); push_exp(4, -512); push_exp(7, 1024); push_exp(10, -512);
        start_step(1'b1, 4'b0101, 3'b010, 16'sd4096, 8'd2, acc);
        wait_done("single");
        check("single_writes", we_cnt, 4);
        check("single_rmw_cycles", last_we - first_rd + 1, 12);
        check("single_first_rd_latency", first_rd - acc, 3);
        check("single_done_after_last_wr", done_cyc - last_we, 2);

        // Clamp at both rails.
        clear_mem();
        mem[0] = 16'sd16300; mem[3] = -16'sd16300; mem[9] = 16'sd100;
        push_exp(0, 16384); push_exp(3, -16384); push_exp(6, -512); push_exp(9, 1124);
        start_step(1'b1, 4'b1001, 3'b001, 16'sd4096, 8'd2, acc);
        wait_done("clamp");

        // Shift past the word width on a negative eta gives dltp=dltd=-1.
        push_exp(2, -1); push_exp(5, 1); push_exp(8, -1); push_exp(11, 1);
        start_step(1'b1, 4'b0101, 3'b100, -16'sd4096, 8'd20, acc);
        wait_done("bigshift");

        // Inverted window: result is always wmax.
        wmin = 16'sd100; wmax = -16'sd100;
        push_exp(2, -100); push_exp(5, -100); push_exp(8, -100); push_exp(11, -100);
        start_step(1'b1, 4'b0011, 3'b100, 16'sd4096, 8'd2, acc);
        wait_done("inverted");
        wmin = -16'sd16384; wmax = 16'sd16384;

        // Skip column 1.
        clear_mem();
        push_exp(0, -512); push_exp(3, 1024); push_exp(6, 1024); push_exp(9, -512);
        push_exp(2, -512); push_exp(5, 1024); push_exp(8, 1024); push_exp(11, -512);
        start_step(1'b1, 4'b0110, 3'b101, 16'sd4096, 8'd2, acc);
        wait_done("skip");
        check("skip_writes", we_cnt, 8);

        // Arbitration stall of 5 cycles on the first read.
        clear_mem();
        rd_gnt = 1'b0;
        push_exp(1, 1024); push_exp(4, 1024); push_exp(7, 1024); push_exp(10, 1024);
        start_step(1'b1, 4'b1111, 3'b010, 16'sd4096, 8'd2, acc);
        k = 0;
        while (!rd_req && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        check("stall_rd_req_seen", int'(rd_req), 1);
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (!rd_req || rd_addr != 4'd1 || w_we) bad++;
        end
        check("stall_hold_bad_cycles", bad, 0);
        @(posedge clk); #1;
        rd_gnt = 1'b1;
        @(negedge clk);
        check("stall_grant_cycle_req_addr", int'({rd_req, rd_addr}), 5'h11);
        check("stall_grant_cycle_w_we", int'(w_we), 0);
        @(negedge clk);
        check("stall_wait_cycle_w_we", int'(w_we), 0);
        @(negedge clk);
        check("stall_wr_cycle_w_we", int'(w_we), 1);
        @(posedge clk); #1;
        wait_done("stall");

        // No-op steps: learning disabled, then no post spikes.
        start_step(1'b0, 4'b1111, 3'b111, 16'sd4096, 8'd2, acc);
        wait_done("disabled");
        check("disabled_done_latency", done_cyc - acc, 1);
        check("disabled_rd_req_cycles", rd_cnt, 0);
        start_step(1'b1, 4'b1111, 3'b000, 16'sd4096, 8'd2, acc);
        wait_done("nopost");
        check("nopost_done_latency", done_cyc - acc, 1);
        check("nopost_rd_req_cycles", rd_cnt, 0);

        // Reset while in WAIT: no write may follow.
        clear_mem();
        start_step(1'b1, 4'b1111, 3'b001, 16'sd4096, 8'd2, acc);
        k = 0;
        while (!rd_req && k < 20) begin
            @(negedge clk); #1;
            k++;
        end
        check("midrst_rd_req_seen", int'(rd_req), 1);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        check("midrst_step_ready_busy", int'({step_ready, busy}), 2);
        check("midrst_strobes", int'({rd_req, w_we, done}), 0);
        check("midrst_addrs_data", int'({rd_addr, w_addr, w_wdata}), 0);
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("midrst_writes_after", we_cnt, 0);
        check("midrst_idle", int'({step_ready, busy}), 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
